// File: rtl/ssg_bus_master.sv
// Byte-serial command master for the SSG sound chip: turns one host command into a
// 2- or 3-byte strobed frame, pacing bytes on BR/BUSY and aborting on a BR timeout.
module ssg_bus_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [1:0]  ReqType,
  input  logic [1:0]  ReqChannel,
  input  logic [11:0] ReqValue,
  input  logic [7:0]  ReqAddress,
  output logic        CE,
  output logic [1:0]  BusControl,
  output logic [7:0]  Data,
  input  logic        BUSY,
  input  logic        BR,
  output logic        Done,
  output logic        Error
);

  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW:0] TO_LIM = TIMEOUT_CYCLES[CW:0];

  typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_DONE} state_t;

  state_t        state_r;
  logic [1:0]    type_r;
  logic [1:0]    chan_r;
  logic [11:0]   value_r;
  logic [7:0]    addr_r;
  logic [1:0]    idx_r;
  logic [CW-1:0] tcnt_r;
  logic          ready_r;
  logic          ce_r;
  logic [1:0]    bc_r;
  logic [7:0]    data_r;
  logic          done_r;
  logic          err_r;

  logic [9:0]    first_s;
  logic [9:0]    next_s;
  logic          last_s;
  logic [CW:0]   tnext_s;
  logic          to_hit_s;

  // {BusControl, Data} of byte idx for a frame of the given type
  function automatic logic [9:0] frame_byte(input logic [1:0] typ, input logic [1:0] ch,
                                            input logic [11:0] val, input logic [7:0] addr,
                                            input logic [1:0] idx);
    logic [9:0] b;
    b = 10'h000;
    case (typ)
      2'b00: b = (idx == 2'd0) ? {2'b01, 2'b00, ch, val[11:8]} : {2'b11, val[7:0]};
      2'b01: b = (idx == 2'd0) ? {2'b01, 8'h40} : {2'b11, val[7:0]};
      2'b10: begin
        case (idx)
          2'd0:    b = {2'b01, 8'h80};
          2'd1:    b = {2'b10, addr};
          default: b = {2'b11, 2'b00, val[5:0]};
        endcase
      end
      default: b = 10'h000;
    endcase
    return b;
  endfunction

  // index of the final byte of a frame
  function automatic logic [1:0] frame_last(input logic [1:0] typ);
    logic [1:0] l;
    case (typ)
      2'b10:   l = 2'd2;
      default: l = 2'd1;
    endcase
    return l;
  endfunction

  // byte selection and BR-timeout detection
  always_comb begin
    first_s  = frame_byte(ReqType, ReqChannel, ReqValue, ReqAddress, 2'd0);
    next_s   = frame_byte(type_r, chan_r, value_r, addr_r, idx_r);
    last_s   = (idx_r == frame_last(type_r));
    tnext_s  = {1'b0, tcnt_r} + {{CW{1'b0}}, 1'b1};
    if (TO_LIM != {(CW+1){1'b0}}) begin
      to_hit_s = (tnext_s >= TO_LIM);
    end else begin
      to_hit_s = 1'b0;
    end
  end

  // frame sequencer; every output is a register written here
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      type_r  <= 2'b00;
      chan_r  <= 2'b00;
      value_r <= 12'h000;
      addr_r  <= 8'h00;
      idx_r   <= 2'd0;
      tcnt_r  <= {CW{1'b0}};
      ready_r <= 1'b0;
      ce_r    <= 1'b0;
      bc_r    <= 2'b00;
      data_r  <= 8'h00;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ReqValid && ready_r) begin
            type_r  <= ReqType;
            chan_r  <= ReqChannel;
            value_r <= ReqValue;
            addr_r  <= ReqAddress;
            idx_r   <= 2'd0;
            tcnt_r  <= {CW{1'b0}};
            if (ReqType == 2'b11) begin
              err_r   <= 1'b1;
              ready_r <= ~BUSY;
            end else begin
              state_r        <= SEND;
              ready_r        <= 1'b0;
              ce_r           <= 1'b1;
              {bc_r, data_r} <= first_s;
            end
          end else begin
            ready_r <= ~BUSY;
          end
        end
        SEND: begin
          // acknowledge takes priority over a timeout landing on the same edge
          if (BR) begin
            ce_r    <= 1'b0;
            bc_r    <= 2'b00;
            data_r  <= 8'h00;
            tcnt_r  <= {CW{1'b0}};
            idx_r   <= idx_r + 2'd1;
            state_r <= last_s ? WAIT_DONE : GAP;
          end else if (to_hit_s) begin
            ce_r    <= 1'b0;
            bc_r    <= 2'b00;
            data_r  <= 8'h00;
            tcnt_r  <= {CW{1'b0}};
            err_r   <= 1'b1;
            ready_r <= ~BUSY;
            state_r <= IDLE;
          end else if (!tnext_s[CW]) begin
            tcnt_r <= tnext_s[CW-1:0];
          end else begin
            tcnt_r <= tcnt_r;
          end
        end
        GAP: begin
          if (!BUSY) begin
            state_r        <= SEND;
            ce_r           <= 1'b1;
            {bc_r, data_r} <= next_s;
          end else begin
            state_r <= GAP;
          end
        end
        WAIT_DONE: begin
          if (!BUSY) begin
            done_r  <= 1'b1;
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          ce_r    <= 1'b0;
          bc_r    <= 2'b00;
          data_r  <= 8'h00;
        end
      endcase
    end
  end

  assign ReqReady   = ready_r;
  assign CE         = ce_r;
  assign BusControl = bc_r;
  assign Data       = data_r;
  assign Done       = done_r;
  assign Error      = err_r;

endmodule

// File: tb/tb_ssg_bus_master.sv
// Randomized bench for ssg_bus_master: a frame-level reference model predicts the
// byte list and Done/Error outcome of each command; a responsive SSG model drives BR/BUSY.
module tb_ssg_bus_master;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ReqValid;
  logic        ReqReady;
  logic [1:0]  ReqType;
  logic [1:0]  ReqChannel;
  logic [11:0] ReqValue;
  logic [7:0]  ReqAddress;
  logic        CE;
  logic [1:0]  BusControl;
  logic [7:0]  Data;
  logic        BUSY;
  logic        BR;
  logic        Done;
  logic        Error;

  int n_checks = 0;
  int n_errors = 0;

  ssg_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqType(ReqType), .ReqChannel(ReqChannel), .ReqValue(ReqValue),
    .ReqAddress(ReqAddress), .CE(CE), .BusControl(BusControl), .Data(Data),
    .BUSY(BUSY), .BR(BR), .Done(Done), .Error(Error)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one command and play the SSG side; br_dly = CE-high cycles before BR (0 = never),
  // BUSY is held for busy_n cycles after byte number busy_at is acknowledged.
  task automatic run_frame(input logic [1:0] t, input logic [1:0] ch, input logic [11:0] v,
                           input logic [7:0] a, input int br_dly, input int busy_at,
                           input int busy_n);
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [9:0] cur;
    int exp_done, exp_err, dones, errs, hi, bsy, hdr, n;
    bit to_case, finished, ce_prev, busy_edge, rdy_end;
    cur = 10'h000; dones = 0; errs = 0; hi = 0; bsy = 0; exp_done = 0; exp_err = 0;
    finished = 0; ce_prev = 0; rdy_end = 0;
    to_case = (br_dly == 0) || (br_dly > TO);
    hdr = int'(ch) * 16 + int'(v) / 256;
    case (t)
      2'd0: begin exp_q.push_back({2'b01, 8'(hdr)}); exp_q.push_back({2'b11, 8'(v % 256)}); end
      2'd1: begin exp_q.push_back({2'b01, 8'h40}); exp_q.push_back({2'b11, 8'(v % 256)}); end
      2'd2: begin
        exp_q.push_back({2'b01, 8'h80});
        exp_q.push_back({2'b10, a});
        exp_q.push_back({2'b11, 8'(v % 64)});
      end
      default: exp_err = 1;
    endcase
    if (t != 2'd3) begin
      if (to_case) begin
        while (exp_q.size() > 1) exp_q.pop_back();
        exp_err = 1;
      end else begin
        exp_done = 1;
      end
    end

    for (int c = 0; c < 60 && !ReqReady; c++) @(negedge CLK);
    check_val("ready_wait", ReqReady, 1);
    ReqValid = 1'b1; ReqType = t; ReqChannel = ch; ReqValue = v; ReqAddress = a;
    @(posedge CLK); busy_edge = BUSY;
    @(negedge CLK);
    ReqValid = 1'b0;
    ReqType = 2'($urandom); ReqChannel = 2'($urandom);
    ReqValue = 12'($urandom); ReqAddress = 8'($urandom);

    for (int c = 0; c < 300 && !finished; c++) begin
      if (Done) begin dones++; check_val("done_busy", busy_edge, 0); end
      if (Error) errs++;
      if (Done || Error) begin finished = 1; rdy_end = ReqReady; end
      if (CE) begin
        if (!ce_prev) begin
          check_val("rise_busy", busy_edge, 0);
          cur = {BusControl, Data};
          got_q.push_back(cur);
          hi = 0;
        end else begin
          check_val("hold", {BusControl, Data}, cur);
        end
        hi++;
        BR = (br_dly != 0) && (hi == br_dly);
      end else begin
        if (ce_prev) begin
          if (to_case) check_val("to_len", hi, TO);
          else check_val("br_len", hi, br_dly);
          if (got_q.size() == busy_at) bsy = busy_n;
        end
        BR = 1'b0;
      end
      BUSY = (bsy > 0);
      if (bsy > 0) bsy--;
      ce_prev = CE;
      if (!finished) begin
        @(posedge CLK); busy_edge = BUSY;
        @(negedge CLK);
      end
    end
    BR = 1'b0; BUSY = 1'b0;

    check_val("frame_end", finished, 1);
    check_val("nbytes", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val("byte", got_q[i], exp_q[i]);
    check_val("done_cnt", dones, exp_done);
    check_val("err_cnt", errs, exp_err);
    if (finished) check_val("ready_end", rdy_end, 1);
  endtask

  initial begin
    RST = 1'b0; BUSY = 1'b1; BR = 1'b0; ReqValid = 1'b0;
    ReqType = 2'b00; ReqChannel = 2'b00; ReqValue = 12'h000; ReqAddress = 8'h00;

    // reset state, then BUSY high at power-up keeps ReqReady low
    #12;
    check_val("rst_ce", CE, 0);
    check_val("rst_bc", BusControl, 0);
    check_val("rst_data", Data, 0);
    check_val("rst_ready", ReqReady, 0);
    check_val("rst_done", Done, 0);
    check_val("rst_err", Error, 0);
    @(negedge CLK); RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check_val("busy_ready", ReqReady, 0);
    end
    BUSY = 1'b0;
    @(negedge CLK);
    check_val("ready_rise", ReqReady, 1);

    // directed frames
    run_frame(2'd0, 2'd2, 12'hA5C, 8'h00, 2, 0, 0);
    run_frame(2'd2, 2'd1, 12'h02B, 8'h3F, 2, 2, 5);
    run_frame(2'd0, 2'd1, 12'h123, 8'h00, 0, 0, 0);
    run_frame(2'd3, 2'd0, 12'h000, 8'h00, 1, 0, 0);
    run_frame(2'd1, 2'd0, 12'h0AA, 8'h00, 4, 0, 0);

    // reset during byte 2 of a wavetable write
    for (int c = 0; c < 20 && !ReqReady; c++) @(negedge CLK);
    ReqValid = 1'b1; ReqType = 2'd2; ReqAddress = 8'h55; ReqValue = 12'h011;
    @(posedge CLK); @(negedge CLK);
    ReqValid = 1'b0; BR = 1'b1;
    @(posedge CLK); @(negedge CLK);
    BR = 1'b0;
    @(posedge CLK); #1;
    check_val("mid_ce", CE, 1);
    check_val("mid_bc", BusControl, 2'b10);
    #2 RST = 1'b0;
    #1;
    check_val("arst_ce", CE, 0);
    check_val("arst_bc", BusControl, 0);
    check_val("arst_data", Data, 0);
    check_val("arst_done", Done, 0);
    check_val("arst_err", Error, 0);
    repeat (2) @(negedge CLK);
    check_val("arst_done2", Done, 0);
    RST = 1'b1;
    run_frame(2'd1, 2'd0, 12'h00F, 8'h00, 2, 0, 0);

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      run_frame(2'($urandom), 2'($urandom), 12'($urandom), 8'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
